// File: rtl/alu_pkg.sv
// Shared ALU opcode encoding and result packet layout for the ALU stream unit.
// alu_res_t fixes the default 32-bit/8-bit layout; parameterised instances derive their own.
package alu_pkg;

  localparam int ALU_CTRL_W    = 3;
  localparam int ALU_DEF_WIDTH = 32;
  localparam int ALU_DEF_TAG_W = 8;

  typedef enum logic [ALU_CTRL_W-1:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLT = 3'b101,
    ALU_SLL = 3'b110,
    ALU_SRL = 3'b111
  } alu_op_t;

  typedef struct packed {
    logic [ALU_DEF_WIDTH-1:0] result;
    logic                     zero;
    logic                     ovf;
    logic [ALU_DEF_TAG_W-1:0] tag;
  } alu_res_t;

endpackage

// File: rtl/alu_stream_fifo.sv
// Synchronous first-word-fall-through FIFO of result packets; head is valid whenever !empty.
// One-cycle write-to-head latency; the producer must respect full (the credit loop guarantees it).
module alu_stream_fifo #(
  parameter int  DEPTH = 4,
  parameter type PKT_T = logic [7:0]
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  PKT_T push_data,
  input  logic pop,
  output PKT_T head,
  output logic empty,
  output logic full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  PKT_T          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  // Storage is not reset; only pointers and occupancy define what is visible.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));

  assert property (@(posedge clk) disable iff (!reset) !(push && full));
  assert property (@(posedge clk) disable iff (!reset) !(pop && empty));

endmodule

// File: rtl/alu_stream_unit.sv
// Handshaked two-stage ALU: S1 captures the op, S2 computes into an FWFT result FIFO.
// in_ready depends only on the registered credit count, so out_ready never reaches it combinationally.
module alu_stream_unit
  import alu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int TAG_W      = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ALU_CTRL_W-1:0] in_ctrl,
  input  logic [WIDTH-1:0]      in_a,
  input  logic [WIDTH-1:0]      in_b,
  input  logic [TAG_W-1:0]      in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_result,
  output logic                  out_zero,
  output logic                  out_ovf,
  output logic [TAG_W-1:0]      out_tag
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] CRED_MAX = CW'(FIFO_DEPTH);

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             ovf;
    logic [TAG_W-1:0] tag;
  } res_pkt_t;

  function automatic res_pkt_t alu_compute(input logic [ALU_CTRL_W-1:0] ctrl,
                                           input logic [WIDTH-1:0]      a,
                                           input logic [WIDTH-1:0]      b,
                                           input logic [TAG_W-1:0]      tag);
    res_pkt_t         p;
    logic [WIDTH-1:0] r;
    logic             ovf;
    r   = '0;
    ovf = 1'b0;
    case (alu_op_t'(ctrl))
      ALU_ADD: begin
        r   = a + b;
        ovf = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_SUB: begin
        r   = a - b;
        ovf = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_AND: r = a & b;
      ALU_OR:  r = a | b;
      ALU_XOR: r = a ^ b;
      ALU_SLT: r = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLL: r = a << b[4:0];
      ALU_SRL: r = a >> b[4:0];
      default: r = '0;
    endcase
    p.result = r;
    p.zero   = (r == '0);
    p.ovf    = ovf;
    p.tag    = tag;
    return p;
  endfunction

  logic [CW-1:0]         credits;
  logic                  s1_valid;
  logic [ALU_CTRL_W-1:0] s1_ctrl;
  logic [WIDTH-1:0]      s1_a;
  logic [WIDTH-1:0]      s1_b;
  logic [TAG_W-1:0]      s1_tag;

  logic     accept;
  logic     pop;
  res_pkt_t s2_pkt;
  res_pkt_t head;
  logic     fifo_empty;
  logic     fifo_full;

  assign in_ready = (credits != '0);
  assign accept   = in_valid && in_ready;
  assign pop      = out_valid && out_ready;

  // Credits cover every op between acceptance and pop, so the FIFO can never be pushed while full.
  always_ff @(posedge clk) begin
    if (!reset) begin
      credits <= CRED_MAX;
    end else begin
      case ({accept, pop})
        2'b10:   credits <= credits - CW'(1);
        2'b01:   credits <= credits + CW'(1);
        default: credits <= credits;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_ctrl  <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_tag   <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_ctrl <= in_ctrl;
        s1_a    <= in_a;
        s1_b    <= in_b;
        s1_tag  <= in_tag;
      end
    end
  end

  assign s2_pkt = alu_compute(s1_ctrl, s1_a, s1_b, s1_tag);

  alu_stream_fifo #(
    .DEPTH (FIFO_DEPTH),
    .PKT_T (res_pkt_t)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (s1_valid),
    .push_data (s2_pkt),
    .pop       (pop),
    .head      (head),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  // Outputs read as zero while empty so stale storage never leaks out after reset.
  assign out_valid  = !fifo_empty;
  assign out_result = fifo_empty ? '0   : head.result;
  assign out_zero   = fifo_empty ? 1'b0 : head.zero;
  assign out_ovf    = fifo_empty ? 1'b0 : head.ovf;
  assign out_tag    = fifo_empty ? '0   : head.tag;

  assert property (@(posedge clk) disable iff (!reset) credits <= CRED_MAX);
  assert property (@(posedge clk) disable iff (!reset) !(s1_valid && fifo_full));

endmodule
